// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings, the responder FSM state type and a funct3 legality helper.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Stores only come in signed flavours; loads additionally allow BU/HU.
   function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
      if (write) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and write-data
// replication, and load extraction with sign/zero extension. Purely
// combinational. Halfword lane follows offset[1], word ignores the offset.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rword[8*offset +: 8];
   assign half_sel = offset[1] ? rword[31:16] : rword[15:0];

   // Lane selection and extension keyed on access size and signedness.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      byte_en   = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = rword;
      case (funct3)
         F3_B, F3_BU: begin
            byte_en   = 4'b0001 << offset;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{(funct3 == F3_B) & byte_sel[7]}}, byte_sel};
         end
         F3_H, F3_HU: begin
            byte_en   = offset[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{(funct3 == F3_H) & half_sel[15]}}, half_sel};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I core: one request at a time over
// valid/ready, LATENCY cycles to response, byte/half/word access with faults.
// Optional build macro DMEM_ALIGN_CHECK_EN turns misaligned half/word accesses
// into faults; without it the low address bits are ignored for those sizes.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   localparam int AW        = $clog2(DEPTH_WORDS);
   localparam int CW        = $clog2(LATENCY + 1);
   localparam int WAIT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          write_q, write_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          fault_q, fault_d;

   logic [31:0]   mem [DEPTH_WORDS];

   // With LATENCY==1 the commit happens on the acceptance edge itself, so the
   // live request is used in IDLE and the latched copy everywhere else.
   logic          cur_write;
   logic [2:0]    cur_funct3;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [AW-1:0] cur_idx;
   logic          enter_resp;
   logic          cur_fault;
   logic          misaligned;
   logic [3:0]    byte_en;
   logic [31:0]   wdata_rep;
   logic [31:0]   rdata_ext;

   assign cur_write  = (state_q == ST_IDLE) ? req_write  : write_q;
   assign cur_funct3 = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
   assign cur_addr   = (state_q == ST_IDLE) ? req_addr   : addr_q;
   assign cur_wdata  = (state_q == ST_IDLE) ? req_wdata  : wdata_q;
   assign cur_idx    = cur_addr[AW+1:2];

   assign enter_resp = ((state_q == ST_IDLE) && req_valid && (LATENCY == 1)) ||
                       ((state_q == ST_WAIT) && (cnt_q == '0));

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                       ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign cur_fault = (cur_addr[31:2] >= 30'(DEPTH_WORDS)) ||
                      !funct3_legal(cur_write, cur_funct3) || misaligned;

   dmem_lane_align u_lane (
      .funct3    (cur_funct3),
      .offset    (cur_addr[1:0]),
      .wdata     (cur_wdata),
      .rword     (mem[cur_idx]),
      .byte_en   (byte_en),
      .wdata_rep (wdata_rep),
      .rdata_ext (rdata_ext)
   );

   // Next-state logic: handshake, wait countdown and response capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      write_d  = write_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (LATENCY == 1) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CW'(WAIT_INIT);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
               rdata_d = '0;
               fault_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (enter_resp) begin
         fault_d = cur_fault;
         rdata_d = (cur_fault || cur_write) ? 32'd0 : rdata_ext;
      end
   end

   // Control and response registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         write_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   // Store commit on the edge entering RESP, one byte lane at a time.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; the write is gated by !rst so a pending store is dropped.
      if (enter_resp && cur_write && !cur_fault && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[cur_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_fault = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// random transactions, compared against a byte-array reference model.
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;
   localparam int REGION = 64;   // bytes tracked by the model

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_fault;
   logic [31:0] rsp_rdata;

   int tests = 0;
   int fails = 0;
   logic [7:0] mdl [REGION];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: returns {fault, rdata} and applies store side effects.
   function automatic logic [32:0] model(input logic w, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] wd);
      int size;
      int base;
      logic [31:0] v;
      bit bad;
      size = 1 << f3[1:0];
      bad  = (a >= 32'(4 * DEPTH));
      if (w) bad = bad || (f3 > 3'd2);
      else   bad = bad || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef DMEM_ALIGN_CHECK_EN
      if (!bad && (a % size != 0)) bad = 1'b1;
`endif
      if (bad) return {1'b1, 32'd0};
      base = int'(a) - int'(a % size);
      if (w) begin
         for (int i = 0; i < size; i++) mdl[base + i] = wd[8*i +: 8];
         return {1'b0, 32'd0};
      end
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(mdl[base + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (~32'd0 << (8 * size));
      return {1'b0, v};
   endfunction

   // One complete transaction; hold = cycles rsp_ready stays low in RESP.
   task automatic do_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold);
      logic [32:0] e;
      logic [31:0] r0;
      int n;
      e = model(w, f3, a, wd);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      // Junk on the request bus must be ignored until IDLE again.
      req_valid = 1'($urandom); req_write = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      n = 1;
      while (!rsp_valid && n < 32) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'(LAT));
      check("rsp_fault", 32'(rsp_fault), 32'(e[32]));
      check("rsp_rdata", rsp_rdata, e[31:0]);
      r0 = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_rdata", rsp_rdata, r0);
         check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check("ready_after_rsp", 32'(req_ready), 32'd1);
      check("valid_after_rsp", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      for (int i = 0; i < REGION; i++) mdl[i] = 8'h00;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Bring the tracked region to a known zero state.
      for (int i = 0; i < REGION / 4; i++) do_txn(1'b1, 3'b010, 32'(4 * i), 32'd0, 0);

      // Word store/load and sub-word extraction.
      do_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
      do_txn(1'b0, 3'b010, 32'h10, 32'h0, 0);
      do_txn(1'b0, 3'b000, 32'h13, 32'h0, 0);
      do_txn(1'b0, 3'b100, 32'h13, 32'h0, 0);
      do_txn(1'b0, 3'b001, 32'h12, 32'h0, 0);
      do_txn(1'b0, 3'b101, 32'h10, 32'h0, 0);
      do_txn(1'b1, 3'b000, 32'h11, 32'h000000AA, 0);
      do_txn(1'b0, 3'b010, 32'h10, 32'h0, 5);

      // Faults: out of range, illegal store funct3, misaligned word.
      do_txn(1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 0);
      do_txn(1'b1, 3'b011, 32'h10, 32'h55555555, 0);
      do_txn(1'b0, 3'b010, 32'h10, 32'h0, 0);
      do_txn(1'b0, 3'b010, 32'h12, 32'h0, 0);

      // Reset during WAIT drops the store.
      do_txn(1'b1, 3'b010, 32'h20, 32'h0, 0);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h20; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_rsp_rdata", rsp_rdata, 32'd0);
      check("midrst_rsp_fault", 32'(rsp_fault), 32'd0);
      @(posedge clk); #1;
      check("midrst_hold_ready", 32'(req_ready), 32'd1);
      check("midrst_hold_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      do_txn(1'b0, 3'b010, 32'h20, 32'h0, 0);

      // Random traffic inside the tracked region, with occasional faults.
      for (int t = 0; t < 300; t++) begin
         w = 1'($urandom);
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
         else begin
            case ($urandom_range(0, 4))
               0: f3 = 3'b000;
               1: f3 = 3'b001;
               2: f3 = 3'b010;
               3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
         end
         if ($urandom_range(0, 7) == 0) a = 32'(4 * DEPTH) + $urandom_range(0, 65535);
         else a = 32'($urandom_range(0, REGION - 1));
         do_txn(w, f3, a, $urandom, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
